parking_gate_controller: RTL and testbench

Automatic parking access controller FSM; the device-under-test end of the sensor/PIN/gate interface that the team's parking bench drives. It watches the entry sensor (sensor_1) and the in-gate sensor (sensor_2), and checks 8-bit PIN attempts. It drives the gate open/close commands, a wrong-PIN alarm, and a block (tailgating) alarm. The block sits between the lane sensors/keypad and the gate actuator.

---
 rtl/parking_gate_controller_if.sv | 22 ++
 rtl/parking_gate_controller.sv | 134 +++++++++++++
 tb/tb_parking_gate_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_controller_if.sv
// Lane-side bundle between the parking bench (sensors/keypad) and the gate controller.
interface parking_gate_controller_if;
  logic       sensor_1;
  logic       sensor_2;
  logic [7:0] psswrd_atmpt;
  logic       try_psswrd;
  logic       alarm_1;
  logic       alarm_2;
  logic       open_gate;
  logic       close_gate;
  logic [2:0] state;

  modport master (
    output sensor_1, sensor_2, psswrd_atmpt, try_psswrd,
    input  alarm_1, alarm_2, open_gate, close_gate, state
  );

  modport slave (
    input  sensor_1, sensor_2, psswrd_atmpt, try_psswrd,
    output alarm_1, alarm_2, open_gate, close_gate, state
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Parking gate access FSM: PIN check, auto-close timeout and tailgate blocking.
//
// state    | meaning
// IDLE     | gate closed, waiting for a car at the entry sensor
// PIN      | car present, counting wrong PIN attempts
// OPEN     | gate open, waiting for the car to pass or the timeout
// BLOCK    | both sensors seen together (tailgate), only a correct PIN clears
// PIN_LOCK | too many wrong PINs, wrong-PIN alarm raised
module parking_gate_controller #(
  parameter logic [7:0] PASSWORD     = 8'h57,
  parameter int         MAX_ATTEMPTS = 3,
  parameter int         GATE_TIMEOUT = 32,
  parameter int         TO_W         = 6
) (
  input logic clk,
  input logic rst,
  parking_gate_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN      = 3'd1,
    OPEN     = 3'd2,
    BLOCK    = 3'd3,
    PIN_LOCK = 3'd4
  } state_t;

  localparam logic [2:0]      MAX_A   = 3'(MAX_ATTEMPTS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GATE_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [2:0]      att_cnt_q, att_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            try_q;
  logic            alarm_1_q, alarm_1_d;
  logic            alarm_2_q, alarm_2_d;
  logic            open_q, open_d;
  logic            close_q, close_d;
  logic            attempt, match, both;

  assign attempt = bus.try_psswrd & ~try_q;
  assign match   = (bus.psswrd_atmpt == PASSWORD);
  assign both    = bus.sensor_1 & bus.sensor_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      att_cnt_q <= '0;
      to_cnt_q  <= '0;
      try_q     <= 1'b0;
      alarm_1_q <= 1'b0;
      alarm_2_q <= 1'b0;
      open_q    <= 1'b0;
      close_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      att_cnt_q <= att_cnt_d;
      to_cnt_q  <= to_cnt_d;
      try_q     <= bus.try_psswrd;
      alarm_1_q <= alarm_1_d;
      alarm_2_q <= alarm_2_d;
      open_q    <= open_d;
      close_q   <= close_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    att_cnt_d = att_cnt_q;
    to_cnt_d  = to_cnt_q;

    if (state_q != BLOCK && both) begin
      state_d   = BLOCK;
      att_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sensor_1) state_d = PIN;
        end
        PIN: begin
          if (attempt && match) begin
            state_d   = OPEN;
            att_cnt_d = '0;
            to_cnt_d  = '0;
          end else if (attempt) begin
            att_cnt_d = att_cnt_q + 3'd1;
            if (att_cnt_q + 3'd1 == MAX_A) state_d = PIN_LOCK;
          end
        end
        PIN_LOCK: begin
          if (attempt && match) begin
            state_d   = OPEN;
            att_cnt_d = '0;
            to_cnt_d  = '0;
          end else if (attempt) begin
            att_cnt_d = MAX_A;
          end
        end
        OPEN: begin
          // Counter value k at an edge means k+1 edges spent in OPEN so far.
          if (bus.sensor_2 && !bus.sensor_1) state_d = IDLE;
          else if (to_cnt_q == TO_LAST)      state_d = IDLE;
          else                               to_cnt_d = to_cnt_q + 1'b1;
        end
        BLOCK: begin
          if (attempt && match) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register with it.
    alarm_1_d = 1'b0;
    alarm_2_d = 1'b0;
    open_d    = 1'b0;
    close_d   = 1'b1;
    case (state_d)
      OPEN: begin
        open_d  = 1'b1;
        close_d = 1'b0;
      end
      BLOCK:    alarm_2_d = 1'b1;
      PIN_LOCK: alarm_1_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.alarm_1    = alarm_1_q;
  assign bus.alarm_2    = alarm_2_q;
  assign bus.open_gate  = open_q;
  assign bus.close_gate = close_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Table-driven bench for parking_gate_controller with an expected-output queue.
module tb_parking_gate_controller;
  localparam int GT = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_PIN = 3'd1, S_OPEN = 3'd2,
                         S_BLOCK = 3'd3, S_LOCK = 3'd4;

  typedef struct {
    logic       s1;
    logic       s2;
    logic       tr;
    logic [7:0] pin;
    logic [2:0] st;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];
  logic [6:0] exp_q[$];

  parking_gate_controller_if bus();

  parking_gate_controller #(
    .PASSWORD(8'h57), .MAX_ATTEMPTS(3), .GATE_TIMEOUT(GT), .TO_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // {alarm_1, alarm_2, open_gate, close_gate} expected for each state
  function automatic logic [3:0] dec(input logic [2:0] st);
    case (st)
      S_OPEN:  return 4'b0010;
      S_BLOCK: return 4'b0101;
      S_LOCK:  return 4'b1001;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic vec_t mk(input logic s1, input logic s2, input logic tr,
                              input logic [7:0] pin, input logic [2:0] st);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.tr = tr; v.pin = pin; v.st = st;
    return v;
  endfunction

  task automatic check_pop(input string name);
    logic [6:0] got;
    logic [6:0] e;
    got = {bus.state, bus.alarm_1, bus.alarm_2, bus.open_gate, bus.close_gate};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got=%b", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s got state=%0d outs=%b expected state=%0d outs=%b",
                 name, got[6:4], got[3:0], e[6:4], e[3:0]);
      end
    end
  endtask

  task automatic step(input string name, input logic s1, input logic s2,
                      input logic tr, input logic [7:0] pin, input logic [2:0] st);
    @(negedge clk);
    bus.sensor_1     = s1;
    bus.sensor_2     = s2;
    bus.try_psswrd   = tr;
    bus.psswrd_atmpt = pin;
    exp_q.push_back({st, dec(st)});
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.sensor_1 = 1'b0;
    bus.sensor_2 = 1'b0;
    bus.try_psswrd = 1'b0;
    bus.psswrd_atmpt = 8'h00;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    exp_q.push_back({S_IDLE, dec(S_IDLE)});
    check_pop("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // normal entry
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, S_PIN));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'h57, S_OPEN));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h57, S_IDLE));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_IDLE));
    // two wrong PINs (one held for 5 cycles), sensor_1 drops in PIN, then correct
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, S_PIN));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'h5F, S_PIN));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h5F, S_PIN));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h5F, S_PIN));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h5F, S_PIN));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h57, S_OPEN));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, S_IDLE));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_IDLE));
    // block from IDLE, wrong PIN holds, correct PIN releases
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, S_BLOCK));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'h5F, S_BLOCK));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h5F, S_BLOCK));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h57, S_IDLE));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_IDLE));
    // tailgate while open
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, S_PIN));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'h57, S_OPEN));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, S_BLOCK));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_BLOCK));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h57, S_IDLE));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_IDLE));
    // attempts in IDLE are ignored
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h57, S_IDLE));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, S_IDLE));

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(nm, vecs[i].s1, vecs[i].s2, vecs[i].tr, vecs[i].pin, vecs[i].st);
    end

    // three wrong PINs lock, a fourth saturates, then async reset mid-cycle
    step("lock_enter", 1'b1, 1'b0, 1'b0, 8'h00, S_PIN);
    for (int i = 0; i < 3; i++) begin
      step("lock_try", 1'b1, 1'b0, 1'b1, 8'h5F, (i == 2) ? S_LOCK : S_PIN);
      step("lock_rel", 1'b1, 1'b0, 1'b0, 8'h5F, (i == 2) ? S_LOCK : S_PIN);
    end
    step("lock_sat", 1'b1, 1'b0, 1'b1, 8'h5F, S_LOCK);
    #2;
    bus.try_psswrd = 1'b0;
    bus.sensor_1 = 1'b0;
    rst = 1'b0;
    #1;
    exp_q.push_back({S_IDLE, dec(S_IDLE)});
    check_pop("async_reset");
    @(negedge clk);
    rst = 1'b1;

    // lock, then correct PIN opens from PIN_LOCK
    step("relock_enter", 1'b1, 1'b0, 1'b0, 8'h00, S_PIN);
    for (int i = 0; i < 3; i++) begin
      step("relock_try", 1'b1, 1'b0, 1'b1, 8'h5F, (i == 2) ? S_LOCK : S_PIN);
      step("relock_rel", 1'b1, 1'b0, 1'b0, 8'h5F, (i == 2) ? S_LOCK : S_PIN);
    end
    step("unlock", 1'b1, 1'b0, 1'b1, 8'h57, S_OPEN);
    step("unlock_pass", 1'b0, 1'b1, 1'b0, 8'h00, S_IDLE);

    // auto-close exactly GT edges after entering OPEN
    step("to_enter", 1'b1, 1'b0, 1'b0, 8'h00, S_PIN);
    step("to_open", 1'b1, 1'b0, 1'b1, 8'h57, S_OPEN);
    for (int k = 1; k <= GT; k++) begin
      step("timeout", 1'b0, 1'b0, 1'b0, 8'h00, (k == GT) ? S_IDLE : S_OPEN);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
